// File: rtl/ace_instbuf_pkg.sv
// Shared decode-front-end constants and the instruction slot type used by
// fetch, the instruction buffer and the decoder.
package ace_instbuf_pkg;

    localparam int FETCH_W = 8;
    localparam int DEC_W   = 4;
    localparam int INST_W  = 32;

    // Width of a per-group instruction count (0..FETCH_W).
    localparam int NPUSH_W = $clog2(FETCH_W + 1);
    // Width of the decoder take request (0..DEC_W, with headroom).
    localparam int TAKE_W  = 3;

    typedef logic [INST_W-1:0] inst_t;

endpackage

// File: rtl/ace_instbuf_if.sv
// Fetch/decoder-facing bundle of the instruction buffer. The master side
// drives the fetch group and the decoder take count; the slave side is the
// buffer itself.
interface ace_instbuf_if #(
    parameter int DEPTH = 32
);
    import ace_instbuf_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic                      flush_i;
    logic                      push_i;
    logic [FETCH_W-1:0]        inst_vld_i;
    inst_t [FETCH_W-1:0]       inst_i;
    logic [TAKE_W-1:0]         dec_take_i;
    logic                      instbuf_full_o;
    logic [DEC_W-1:0]          dec_vld_o;
    inst_t [DEC_W-1:0]         dec_inst_o;
    logic [CW-1:0]             count_o;
    logic                      empty_o;
    logic                      ovf_o;

    modport master (
        output flush_i, push_i, inst_vld_i, inst_i, dec_take_i,
        input  instbuf_full_o, dec_vld_o, dec_inst_o, count_o, empty_o, ovf_o
    );

    modport slave (
        input  flush_i, push_i, inst_vld_i, inst_i, dec_take_i,
        output instbuf_full_o, dec_vld_o, dec_inst_o, count_o, empty_o, ovf_o
    );

endinterface

// File: rtl/ace_instbuf_compact.sv
// Packs the valid slots of a fetch group towards slot 0, keeping ascending
// slot order, so the buffer can write them to consecutive entries.
module ace_instbuf_compact
    import ace_instbuf_pkg::*;
(
    input  logic [FETCH_W-1:0]  inst_vld_i,
    input  inst_t [FETCH_W-1:0] inst_i,
    output inst_t [FETCH_W-1:0] cmp_inst_o,
    output logic [FETCH_W-1:0]  cmp_vld_o,
    output logic [NPUSH_W-1:0]  n_push_o
);

    localparam int SW = $clog2(FETCH_W);

    logic [NPUSH_W-1:0] slot_pos;

    // Each valid slot lands at the number of valid slots below it.
    always_comb begin
        cmp_inst_o = '0;
        cmp_vld_o  = '0;
        slot_pos   = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            if (inst_vld_i[k]) begin
                cmp_inst_o[slot_pos[SW-1:0]] = inst_i[k];
                slot_pos = slot_pos + NPUSH_W'(1);
            end
        end
        for (int k = 0; k < FETCH_W; k++) begin
            cmp_vld_o[k] = (NPUSH_W'(k) < slot_pos);
        end
        n_push_o = slot_pos;
    end

endmodule

// File: rtl/ace_instbuf.sv
// Decode-stage instruction buffer: circular queue fed with compacted fetch
// groups, presenting a program-ordered 4-wide head window to the decoder.
module ace_instbuf
    import ace_instbuf_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic         clock,
    input  logic         reset,
    ace_instbuf_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = CW + 1;

    typedef logic [PW-1:0] ptr_t;

    inst_t               mem [DEPTH];
    ptr_t                head;
    ptr_t                tail;
    logic [CW-1:0]       count;
    logic                ovf;

    inst_t [FETCH_W-1:0] cmp_inst;
    logic [FETCH_W-1:0]  cmp_vld;
    logic [NPUSH_W-1:0]  n_push;

    logic [TAKE_W-1:0]   n_avail;
    logic [TAKE_W-1:0]   n_take;
    logic [EW-1:0]       room;
    logic                ovf_hit;
    logic                do_push;
    logic [NPUSH_W-1:0]  push_amt;

    ace_instbuf_compact u_compact (
        .inst_vld_i (bus.inst_vld_i),
        .inst_i     (bus.inst_i),
        .cmp_inst_o (cmp_inst),
        .cmp_vld_o  (cmp_vld),
        .n_push_o   (n_push)
    );

    // Clamp the take to the valid window; space freed by the take counts
    // towards room for this cycle's group, which is all-or-nothing.
    always_comb begin
        n_avail  = (count >= CW'(DEC_W)) ? TAKE_W'(DEC_W) : count[TAKE_W-1:0];
        n_take   = (bus.dec_take_i < n_avail) ? bus.dec_take_i : n_avail;
        room     = EW'(DEPTH) - EW'(count) + EW'(n_take);
        ovf_hit  = bus.push_i && (EW'(n_push) > room);
        do_push  = bus.push_i && (n_push != '0) && !ovf_hit;
        push_amt = do_push ? n_push : '0;
    end

    // Pointer, occupancy and sticky overflow update; flush clears the queue
    // but leaves the overflow flag alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (bus.flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_take);
            tail  <= tail + PW'(push_amt);
            count <= count + CW'(push_amt) - CW'(n_take);
            if (ovf_hit) begin
                ovf <= 1'b1;
            end
        end
    end

    // Entry storage: write the compacted group at tail, wrapping mod DEPTH.
    always_ff @(posedge clock) begin
        if (!reset && !bus.flush_i && do_push) begin
            for (int j = 0; j < FETCH_W; j++) begin
                if (cmp_vld[j]) begin
                    mem[tail + PW'(j)] <= cmp_inst[j];
                end
            end
        end
    end

    // Head window and status, combinational from registered state only.
    always_comb begin
        for (int i = 0; i < DEC_W; i++) begin
            bus.dec_vld_o[i]  = (count > CW'(i));
            bus.dec_inst_o[i] = mem[head + PW'(i)];
        end
    end

    assign bus.instbuf_full_o = (CW'(DEPTH) - count) < CW'(2 * FETCH_W);
    assign bus.count_o        = count;
    assign bus.empty_o        = (count == '0);
    assign bus.ovf_o          = ovf;

endmodule

// File: tb/tb_ace_instbuf.sv
// Directed bench for ace_instbuf: a vector table for single-cycle behaviour
// plus hand sequences for wrap-around, clamping, reset priority and the
// overflow boundary.
module tb_ace_instbuf;
    import ace_instbuf_pkg::*;

    logic clock;
    logic reset;

    ace_instbuf_if #(.DEPTH(32)) bus ();

    ace_instbuf #(.DEPTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        push;
        logic [7:0]  mask;
        logic [31:0] base;
        logic [2:0]  take;
        logic        flush;
        int          exp_count;
        logic [3:0]  exp_vld;
        logic        exp_full;
        logic        exp_ovf;
        logic [31:0] w0, w1, w2, w3;
    } vec_t;

    int   tests  = 0;
    int   failed = 0;
    vec_t tbl [15];

    function automatic vec_t mk(input logic p, input logic [7:0] m, input logic [31:0] b,
                                input logic [2:0] t, input logic f, input int c,
                                input logic [3:0] v, input logic fu, input logic o,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3);
        vec_t r;
        r.push = p; r.mask = m; r.base = b; r.take = t; r.flush = f;
        r.exp_count = c; r.exp_vld = v; r.exp_full = fu; r.exp_ovf = o;
        r.w0 = a0; r.w1 = a1; r.w2 = a2; r.w3 = a3;
        return r;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, wait for the edge, settle away from it.
    task automatic drive(input logic p, input logic [7:0] m, input logic [31:0] b,
                         input logic [2:0] t, input logic f);
        bus.push_i     = p;
        bus.inst_vld_i = m;
        for (int k = 0; k < FETCH_W; k++) begin
            bus.inst_i[k] = b + 32'(k);
        end
        bus.dec_take_i = t;
        bus.flush_i    = f;
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.push, v.mask, v.base, v.take, v.flush);
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        logic [31:0] w [4];
        w[0] = v.w0; w[1] = v.w1; w[2] = v.w2; w[3] = v.w3;
        checkVal($sformatf("v%0d count", idx), 32'(bus.count_o), 32'(v.exp_count));
        checkVal($sformatf("v%0d empty", idx), 32'(bus.empty_o), 32'(v.exp_count == 0));
        checkVal($sformatf("v%0d vld", idx), 32'(bus.dec_vld_o), 32'(v.exp_vld));
        checkVal($sformatf("v%0d full", idx), 32'(bus.instbuf_full_o), 32'(v.exp_full));
        checkVal($sformatf("v%0d ovf", idx), 32'(bus.ovf_o), 32'(v.exp_ovf));
        for (int i = 0; i < DEC_W; i++) begin
            if (v.exp_vld[i]) begin
                checkVal($sformatf("v%0d win%0d", idx, i), bus.dec_inst_o[i], w[i]);
            end
        end
    endtask

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        bus.push_i = 1'b0; bus.inst_vld_i = '0; bus.inst_i = '0;
        bus.dec_take_i = '0; bus.flush_i = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        //          push mask   base      take flush cnt vld   full ovf window
        tbl[0]  = mk(0, 8'h00, 32'h0,    0, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 8'h00, 32'h0,    0, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 8'h00, 32'h0,    0, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 8'hFF, 32'h1000, 0, 0,  8, 4'hF, 0, 0, 32'h1000, 32'h1001, 32'h1002, 32'h1003);
        tbl[4]  = mk(0, 8'h00, 32'h0,    4, 0,  4, 4'hF, 0, 0, 32'h1004, 32'h1005, 32'h1006, 32'h1007);
        tbl[5]  = mk(0, 8'h00, 32'h0,    4, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 8'hA5, 32'hA0,   0, 0,  4, 4'hF, 0, 0, 32'hA0, 32'hA2, 32'hA5, 32'hA7);
        tbl[7]  = mk(0, 8'h00, 32'h0,    4, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 8'hFF, 32'h100,  0, 0,  8, 4'hF, 0, 0, 32'h100, 32'h101, 32'h102, 32'h103);
        tbl[9]  = mk(1, 8'hFF, 32'h108,  0, 0, 16, 4'hF, 0, 0, 32'h100, 32'h101, 32'h102, 32'h103);
        tbl[10] = mk(1, 8'h01, 32'h110,  0, 0, 17, 4'hF, 1, 0, 32'h100, 32'h101, 32'h102, 32'h103);
        tbl[11] = mk(1, 8'hFF, 32'h120,  0, 0, 25, 4'hF, 1, 0, 32'h100, 32'h101, 32'h102, 32'h103);
        tbl[12] = mk(1, 8'hFF, 32'h130,  0, 0, 25, 4'hF, 1, 1, 32'h100, 32'h101, 32'h102, 32'h103);
        tbl[13] = mk(0, 8'h00, 32'h0,    4, 0, 21, 4'hF, 1, 1, 32'h104, 32'h105, 32'h106, 32'h107);
        tbl[14] = mk(1, 8'hFF, 32'h200,  4, 1,  0, 4'h0, 0, 1, 0, 0, 0, 0);

        for (int n = 0; n < 15; n++) begin
            applyStimulus(tbl[n]);
            checkOutput(tbl[n], n);
        end

        // Steady state across the pointer wrap: 8 preloaded, 4 in / 4 out.
        drive(1, 8'hFF, 32'h5000, 0, 0);
        checkVal("ss preload count", 32'(bus.count_o), 32'd8);
        for (int j = 0; j < 20; j++) begin
            drive(1, 8'h0F, 32'h5008 + 32'(4 * j), 4, 0);
            checkVal($sformatf("ss%0d count", j), 32'(bus.count_o), 32'd8);
            for (int i = 0; i < DEC_W; i++) begin
                checkVal($sformatf("ss%0d win%0d", j, i), bus.dec_inst_o[i],
                         32'h5004 + 32'(4 * j) + 32'(i));
            end
        end

        // Drain to two entries, then over-request a take of four.
        drive(0, 8'h00, 32'h0, 4, 0);
        checkVal("drain4 count", 32'(bus.count_o), 32'd4);
        drive(0, 8'h00, 32'h0, 2, 0);
        checkVal("drain2 count", 32'(bus.count_o), 32'd2);
        checkVal("drain2 vld", 32'(bus.dec_vld_o), 32'h3);
        checkVal("drain2 win0", bus.dec_inst_o[0], 32'h5056);
        checkVal("drain2 win1", bus.dec_inst_o[1], 32'h5057);
        drive(0, 8'h00, 32'h0, 4, 0);
        checkVal("clamp count", 32'(bus.count_o), 32'd0);
        checkVal("clamp vld", 32'(bus.dec_vld_o), 32'h0);
        checkVal("clamp empty", 32'(bus.empty_o), 32'd1);

        // Reset mid-operation wins over a simultaneous push and clears ovf.
        drive(1, 8'hFF, 32'h600, 0, 0);
        reset = 1'b1;
        drive(1, 8'hFF, 32'h608, 0, 0);
        reset = 1'b0;
        checkVal("rst count", 32'(bus.count_o), 32'd0);
        checkVal("rst ovf", 32'(bus.ovf_o), 32'd0);
        checkVal("rst empty", 32'(bus.empty_o), 32'd1);

        // Fill to 25, then a full group fits only because of the same-cycle take.
        drive(1, 8'hFF, 32'h700, 0, 0);
        drive(1, 8'hFF, 32'h708, 0, 0);
        drive(1, 8'hFF, 32'h710, 0, 0);
        drive(1, 8'h01, 32'h718, 0, 0);
        checkVal("fill count", 32'(bus.count_o), 32'd25);
        drive(1, 8'hFF, 32'h720, 1, 0);
        checkVal("edge count", 32'(bus.count_o), 32'd32);
        checkVal("edge ovf", 32'(bus.ovf_o), 32'd0);
        checkVal("edge full", 32'(bus.instbuf_full_o), 32'd1);
        checkVal("edge win0", bus.dec_inst_o[0], 32'h701);
        checkVal("edge win3", bus.dec_inst_o[3], 32'h704);
        drive(1, 8'h01, 32'h800, 0, 0);
        checkVal("fullpush count", 32'(bus.count_o), 32'd32);
        checkVal("fullpush ovf", 32'(bus.ovf_o), 32'd1);

        drive(0, 8'h00, 32'h0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
